wb_stream_writer_burst_ctrl: RTL and testbench
==============================================

# wb_stream_writer_burst_ctrl

Wishbone burst-read master that feeds the stream writer's output FIFO. It sits directly upstream of that FIFO. It fetches a memory buffer (start address, length in words) in incrementing bursts and pushes every acknowledged word into the FIFO. It starts a burst only when the FIFO's occupancy count shows room for the whole burst.

## Interface
- WB_AW, 32, Wishbone byte-address width
- WB_DW, 32, Wishbone/stream data width (multiple of 8)
- FIFO_AW, 4, log2 of downstream FIFO depth; fifo_cnt_i is FIFO_AW+1 bits
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; starts a transfer when idle
- start_adr_i  in  WB_AW  buffer byte address; low log2(WB_DW/8) bits forced to 0
- buf_size_i  in  WB_AW  buffer length in words
- burst_size_i  in  FIFO_AW+1  max beats per burst, clamped to [1, 2^FIFO_AW]
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at transfer completion
- wb_adr_o  out  WB_AW  byte address
- wb_sel_o  out  WB_DW/8  constant all ones
- wb_we_o  out  1  constant 0
- wb_cyc_o, wb_stb_o  out  1 each  cycle/strobe, always equal
- wb_cti_o  out  3  010 incrementing, 111 end of burst
- wb_bte_o  out  2  constant 00, linear
- wb_dat_i  in  WB_DW  read data
- wb_ack_i  in  1  beat acknowledge
- wb_err_i  in  1  bus error (only with macro, see Configuration)
- err_o  out  1  sticky error flag (only with macro)
- fifo_d_o  out  WB_DW  FIFO write data = wb_dat_i
- fifo_wr_o  out  1  FIFO write = wb_cyc_o & wb_ack_i
- fifo_cnt_i  in  FIFO_AW+1  current FIFO occupancy

## Operation
- FSM states:
  - IDLE -> LOAD on start_i. A start_i while not in IDLE is ignored.
  - LOAD latches the address, sets remaining = buf_size_i, and latches the clamped burst size. If remaining = 0 it goes to DONE, otherwise to WAIT.
  - WAIT computes blen = min(burst, remaining) and free = 2^FIFO_AW - fifo_cnt_i. If free >= blen it goes to BURST with beat counter = blen.
  - BURST holds cyc/stb high. Each ack advances the address by WB_DW/8, decrements remaining, and decrements the beat counter. The last beat's ack goes to DONE if remaining reaches 0, otherwise to WAIT.
  - DONE pulses done_o for one cycle, then returns to IDLE.
- wb_cti_o is 111 when the beat counter = 1, otherwise 010. A one-beat burst uses 111 only.
- The address wraps modulo 2^WB_AW with no error.
- The block is the FIFO's only writer, so occupancy can only fall during WAIT. It never pushes into a full FIFO.
- busy_o is high in LOAD, WAIT, BURST and DONE.

## Timing
- Reset values: cyc, stb, busy, done, err_o and fifo_wr are 0. wb_adr is 0 and wb_cti is 000.
- Asserting rst_n low mid-burst drops cyc/stb immediately (asynchronously). No further FIFO writes occur.
- start_i in cycle n puts LOAD in cycle n+1 and WAIT in cycle n+2.
- If space is available, cyc/stb are asserted at cycle n+3.
- With zero-wait-state acks, an N-beat burst occupies exactly N cycles with cyc high. cyc drops on the edge of the last ack.
- The next burst's WAIT evaluation happens in the cycle after the last ack. This gives at least one idle bus cycle between bursts.
- While ack is low, the address, cti and beat counter hold.
- fifo_wr_o is combinational from ack, giving zero latency. fifo_cnt_i updates on the same edge as the write.
- done_o fires one cycle after the final ack.

## Configuration
- Macro: WB_STREAM_WRITER_BURST_CTRL_ERR_EN.
- When defined:
  - wb_err_i and err_o exist.
  - err during BURST drops cyc on that edge, writes nothing to the FIFO for that beat, sets err_o and goes to DONE.
  - err_o is cleared by the next start_i or by reset.
- When undefined, neither port exists and bus errors are not observed.

## Structure
- Shared package wb_stream_pkg holds:
  - CTI constants CTI_CLASSIC = 000, CTI_INC = 010, CTI_EOB = 111
  - BTE_LINEAR = 00
  - the FSM state enum (IDLE, LOAD, WAIT, BURST, DONE)
- Single flat module, no sub-module.

## Test plan
- FIFO_AW=4, start_adr=0x1000, buf_size=8, burst=4, cnt=0, ack every cycle -> two bursts at 0x1000–0x100C and 0x1010–0x101C. cti is 010,010,010,111 in each. 8 FIFO writes match memory. One done_o pulse.
- buf_size=6, burst=4 -> bursts of 4 then 2. The second burst uses cti 010,111.
- fifo_cnt_i held at 13, burst=4 -> cyc stays low. Dropping cnt to 12 -> cyc rises within 2 cycles.
- Acks on alternate cycles -> wb_adr and cti hold through the stall cycles. The FIFO is written only on ack cycles.
- Macro on, err on beat 2 of 4 -> cyc drops and err_o=1. One FIFO write occurs, done_o pulses, busy_o returns to 0.
- buf_size=0 -> no bus cycle, done_o at cycle n+2. Separately, rst_n low mid-burst -> cyc and busy are 0 at once.

Source files
------------

// File: rtl/wb_stream_pkg.sv
// Shared Wishbone stream-writer definitions: bus cycle-type constants and
// the burst controller's state encoding.
package wb_stream_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        BURST = 3'd3,
        DONE  = 3'd4
    } burst_state_t;

endpackage

// File: rtl/wb_stream_writer_burst_ctrl.sv
// Wishbone incrementing-burst reader feeding the stream writer's output FIFO.
// Optional bus-error handling is enabled by WB_STREAM_WRITER_BURST_CTRL_ERR_EN.
module wb_stream_writer_burst_ctrl
    import wb_stream_pkg::*;
#(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WB_AW-1:0]     start_adr_i,
    input  logic [WB_AW-1:0]     buf_size_i,
    input  logic [FIFO_AW:0]     burst_size_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WB_AW-1:0]     wb_adr_o,
    output logic [WB_DW/8-1:0]   wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic [2:0]           wb_cti_o,
    output logic [1:0]           wb_bte_o,
    input  logic [WB_DW-1:0]     wb_dat_i,
    input  logic                 wb_ack_i,
`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
    input  logic                 wb_err_i,
    output logic                 err_o,
`endif
    output logic [WB_DW-1:0]     fifo_d_o,
    output logic                 fifo_wr_o,
    input  logic [FIFO_AW:0]     fifo_cnt_i
);

    localparam int CNT_W = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LSB   = $clog2(WB_DW / 8);
    localparam logic [WB_AW-1:0] ADR_MASK = ~(WB_AW'((1 << LSB) - 1));
    localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(WB_DW / 8);

    burst_state_t state, state_nxt;

    logic [WB_AW-1:0] adr_q;
    logic [WB_AW-1:0] rem_q;
    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] burst_clamped;
    logic [CNT_W-1:0] blen;
    logic [CNT_W-1:0] fifo_free;
    logic             bus_err;

`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
    logic err_q;
    assign bus_err = wb_err_i;
    assign err_o   = err_q;
`else
    assign bus_err = 1'b0;
`endif

    // A burst is only launched when the FIFO can absorb every beat of it.
    always_comb begin
        burst_clamped = burst_size_i;
        if (burst_size_i == '0)
            burst_clamped = CNT_W'(1);
        else if (burst_size_i > CNT_W'(DEPTH))
            burst_clamped = CNT_W'(DEPTH);
        blen      = (rem_q < WB_AW'(burst_q)) ? rem_q[CNT_W-1:0] : burst_q;
        fifo_free = CNT_W'(DEPTH) - fifo_cnt_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_i) state_nxt = LOAD;
            LOAD:  state_nxt = (buf_size_i == '0) ? DONE : WAIT;
            WAIT:  if (fifo_free >= blen) state_nxt = BURST;
            BURST: begin
                if (bus_err)
                    state_nxt = DONE;
                else if (wb_ack_i && beats_q == CNT_W'(1))
                    state_nxt = (rem_q == WB_AW'(1)) ? DONE : WAIT;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q   <= '0;
            rem_q   <= '0;
            burst_q <= '0;
            beats_q <= '0;
        end else begin
            case (state)
                LOAD: begin
                    adr_q   <= start_adr_i & ADR_MASK;
                    rem_q   <= buf_size_i;
                    burst_q <= burst_clamped;
                end
                WAIT: if (fifo_free >= blen) beats_q <= blen;
                BURST: if (wb_ack_i && !bus_err) begin
                    adr_q   <= adr_q + ADR_STEP;
                    rem_q   <= rem_q - WB_AW'(1);
                    beats_q <= beats_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
    // Sticky until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state == IDLE && start_i)
            err_q <= 1'b0;
        else if (state == BURST && wb_err_i)
            err_q <= 1'b1;
    end
`endif

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign wb_cyc_o  = (state == BURST);
    assign wb_stb_o  = wb_cyc_o;
    assign wb_adr_o  = adr_q;
    assign wb_cti_o  = !wb_cyc_o ? CTI_CLASSIC :
                       (beats_q == CNT_W'(1)) ? CTI_EOB : CTI_INC;
    assign wb_sel_o  = '1;
    assign wb_we_o   = 1'b0;
    assign wb_bte_o  = BTE_LINEAR;
    assign fifo_d_o  = wb_dat_i;
    assign fifo_wr_o = wb_cyc_o & wb_ack_i & ~bus_err;

endmodule

// File: tb/tb_wb_stream_writer_burst_ctrl.sv
// Scoreboard bench for wb_stream_writer_burst_ctrl: expected beats are queued
// by the stimulus, a negedge monitor checks every bus cycle and FIFO write.
module tb_wb_stream_writer_burst_ctrl;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int FIFO_AW = 4;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [31:0] dat;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [31:0]       start_adr_i = '0;
    logic [31:0]       buf_size_i = '0;
    logic [4:0]        burst_size_i = '0;
    logic              busy_o, done_o;
    logic [31:0]       wb_adr_o;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;
    logic [31:0]       fifo_d_o;
    logic              fifo_wr_o;
    logic [4:0]        fifo_cnt_i = '0;
`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
    logic              wb_err_i;
    logic              err_o;
`endif

    logic ack_en = 1'b1;
    logic alt_mode = 1'b0;
    logic stall_mode = 1'b0;
    logic err_force = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cyc_cnt = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign wb_dat_i = mem_data(wb_adr_o);
    assign wb_ack_i = wb_cyc_o & ack_en & ~err_force;
`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
    assign wb_err_i = wb_cyc_o & err_force;
`endif

    wb_stream_writer_burst_ctrl #(
        .WB_AW(WB_AW), .WB_DW(WB_DW), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .start_adr_i(start_adr_i), .buf_size_i(buf_size_i),
        .burst_size_i(burst_size_i), .busy_o(busy_o), .done_o(done_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
        .wb_err_i(wb_err_i), .err_o(err_o),
`endif
        .fifo_d_o(fifo_d_o), .fifo_wr_o(fifo_wr_o), .fifo_cnt_i(fifo_cnt_i)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: condition not met", name);
    endtask

    // Slave ack pattern: always, alternate cycles, or stalled.
    always @(posedge clk) begin
        #1;
        if (stall_mode)    ack_en = 1'b0;
        else if (alt_mode) ack_en = ~ack_en;
        else               ack_en = 1'b1;
    end

    // Monitor: each bus cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_o) done_cnt++;
            if (wb_cyc_o) cyc_cnt++;
            if (wb_cyc_o || fifo_wr_o) begin
                checkOutput("fifo_wr", 32'(fifo_wr_o), 32'(wb_cyc_o && wb_ack_i));
                checkOutput("stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
            end
            if (wb_cyc_o) begin
                if (exp_q.size() == 0) begin
                    reportFail("unexpected_bus_cycle");
                end else begin
                    checkOutput("wb_adr", wb_adr_o, exp_q[0].adr);
                    checkOutput("wb_cti", 32'(wb_cti_o), 32'(exp_q[0].cti));
                    if (wb_ack_i) begin
                        checkOutput("fifo_d", fifo_d_o, exp_q[0].dat);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic pushExpected(input logic [31:0] a0, input int size, input int burst);
        int b = (burst == 0) ? 1 : (burst > 16) ? 16 : burst;
        int rem = size;
        logic [31:0] a = a0 & 32'hFFFF_FFFC;
        while (rem > 0) begin
            int blen = (rem < b) ? rem : b;
            for (int k = 0; k < blen; k++) begin
                exp_q.push_back('{adr: a, cti: (k == blen - 1) ? 3'b111 : 3'b010, dat: mem_data(a)});
                a = a + 32'd4;
            end
            rem -= blen;
        end
    endtask

    task automatic startXfer(input logic [31:0] a, input int size, input int burst);
        @(posedge clk); #1;
        start_adr_i  = a;
        buf_size_i   = 32'(size);
        burst_size_i = 5'(burst);
        start_i      = 1'b1;
        @(posedge clk); #1;
        start_i      = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        if (!seen) reportFail({name, "_done_timeout"});
        @(posedge clk); #1;
    endtask

    // Full transfer: optional start-latency check, then completion checks.
    task automatic applyStimulus(input string name, input logic [31:0] a, input int size,
                                 input int burst, input bit chk_lat, input bit chk_cyc);
        int d0 = done_cnt;
        int c0 = cyc_cnt;
        pushExpected(a, size, burst);
        startXfer(a, size, burst);
        checkOutput({name, "_busy_load"}, 32'(busy_o), 32'd1);
        if (chk_lat) begin
            @(posedge clk); #1;
            checkOutput({name, "_cyc_n2"}, 32'(wb_cyc_o), 32'd0);
            @(posedge clk); #1;
            checkOutput({name, "_cyc_n3"}, 32'(wb_cyc_o), 32'd1);
        end
        waitDone(name);
        checkOutput({name, "_busy_end"}, 32'(busy_o), 32'd0);
        checkOutput({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        checkOutput({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        if (chk_cyc) checkOutput({name, "_cyc_cycles"}, 32'(cyc_cnt - c0), 32'(size));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, c0;
        #12;
        checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_fifo_wr", 32'(fifo_wr_o), 32'd0);
        checkOutput("rst_adr", wb_adr_o, 32'd0);
        checkOutput("rst_cti", 32'(wb_cti_o), 32'd0);
        checkOutput("sel", 32'(wb_sel_o), 32'hF);
        checkOutput("we", 32'(wb_we_o), 32'd0);
        checkOutput("bte", 32'(wb_bte_o), 32'd0);
`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
        checkOutput("rst_err", 32'(err_o), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus("two_bursts", 32'h1000, 8, 4, 1'b1, 1'b1);
        applyStimulus("four_two", 32'h2000, 6, 4, 1'b1, 1'b1);
        applyStimulus("clamp_zero", 32'h3000, 3, 0, 1'b1, 1'b1);
        applyStimulus("clamp_big", 32'h4000, 20, 31, 1'b1, 1'b1);
        applyStimulus("wrap_unaligned", 32'hFFFF_FFFA, 4, 4, 1'b1, 1'b1);

        // FIFO nearly full: 3 free slots cannot take a 4-beat burst.
        fifo_cnt_i = 5'd13;
        c0 = cyc_cnt;
        d0 = done_cnt;
        pushExpected(32'h5000, 4, 4);
        startXfer(32'h5000, 4, 4);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("full_no_cyc", 32'(cyc_cnt - c0), 32'd0);
        fifo_cnt_i = 5'd12;
        @(posedge clk); #1;
        checkOutput("room_cyc_rises", 32'(wb_cyc_o), 32'd1);
        waitDone("room");
        checkOutput("room_done_pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("room_queue_left", 32'(exp_q.size()), 32'd0);
        fifo_cnt_i = 5'd0;

        alt_mode = 1'b1;
        applyStimulus("alt_ack", 32'h6000, 6, 4, 1'b0, 1'b0);
        alt_mode = 1'b0;

        // Empty buffer: done directly out of LOAD, never a bus cycle.
        d0 = done_cnt;
        c0 = cyc_cnt;
        startXfer(32'h7000, 0, 4);
        @(posedge clk); #1;
        checkOutput("zero_done_n2", 32'(done_o), 32'd1);
        @(posedge clk); #1;
        checkOutput("zero_busy_end", 32'(busy_o), 32'd0);
        checkOutput("zero_no_cyc", 32'(cyc_cnt - c0), 32'd0);
        checkOutput("zero_done_pulses", 32'(done_cnt - d0), 32'd1);

`ifdef WB_STREAM_WRITER_BURST_CTRL_ERR_EN
        // Error on beat 2 of 4: beat 1 written, beat 2 dropped.
        d0 = done_cnt;
        pushExpected(32'h8000, 2, 4);
        exp_q[1].cti = 3'b010;
        startXfer(32'h8000, 4, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        err_force = 1'b1;
        @(posedge clk); #1;
        err_force = 1'b0;
        checkOutput("err_cyc_drop", 32'(wb_cyc_o), 32'd0);
        checkOutput("err_flag", 32'(err_o), 32'd1);
        checkOutput("err_done", 32'(done_o), 32'd1);
        checkOutput("err_one_write", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        checkOutput("err_busy_end", 32'(busy_o), 32'd0);
        startXfer(32'h9000, 2, 4);
        checkOutput("err_cleared", 32'(err_o), 32'd0);
        pushExpected(32'h9000, 2, 4);
        waitDone("after_err");
        checkOutput("after_err_queue", 32'(exp_q.size()), 32'd0);
`endif

        // Reset in the middle of a stalled burst.
        stall_mode = 1'b1;
        pushExpected(32'hA000, 4, 4);
        startXfer(32'hA000, 4, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("async_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("async_rst_fifo_wr", 32'(fifo_wr_o), 32'd0);
        exp_q.delete();
        stall_mode = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus("post_reset", 32'hB000, 4, 2, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
